// File: rtl/spi_link_pkg.sv
// spi_link_pkg
//   Shared definitions for the board-to-board SPI link scheduler:
//   word width, default frame header word and the FSM state encoding
//   (the encoding is visible on state_dbg, so the values are fixed).
package spi_link_pkg;

  localparam int SPI_W = 32;
  localparam logic [SPI_W-1:0] SPI_SYNC_WORD = 32'hA5A5_5A5A;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_START   = 3'd2,
    ST_WAIT_HI = 3'd3,
    ST_WAIT_LO = 3'd4,
    ST_NEXT    = 3'd5
  } state_e;

endpackage

// File: rtl/spi_link_scheduler_prio.sv
// prio_next_idx
//   Combinational finder: lowest set bit of mask strictly above cur_idx.
//   When from_sync is high the current slot is the SYNC word, which ranks
//   below channel 0, so every enabled channel is a candidate.
// Ports
//   mask       in  NCH  channel enables
//   from_sync  in  1    current slot is SYNC
//   cur_idx    in  3    current channel index (ignored when from_sync)
//   next_idx   out 3    lowest qualifying index (0 when none)
//   found      out 1    a qualifying index exists
module prio_next_idx #(
  parameter int NCH = 4
) (
  input  logic [NCH-1:0] mask,
  input  logic           from_sync,
  input  logic [2:0]     cur_idx,
  output logic [2:0]     next_idx,
  output logic           found
);

  // Scan downwards so the lowest qualifying index is the last one written.
  always_comb begin
    found    = 1'b0;
    next_idx = 3'd0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i] && (from_sync || (i > int'(cur_idx)))) begin
        found    = 1'b1;
        next_idx = 3'(i);
      end
    end
  end

endmodule

// File: rtl/spi_link_scheduler.sv
// spi_link_scheduler
//   Time-division scheduler for the single board-to-board SPI master link.
//   A frame is one SYNC word followed by one word per enabled channel in
//   ascending index order. Channels without new data resend their last
//   word (counted in drop_cnt). Each word is handed to spi_master with a
//   one-cycle tx_start and the scheduler then waits for tx_busy to rise
//   and fall; a phase lasting TMO cycles aborts the frame (timeout_err).
// Ports
//   sim_clk, reset_global  clock, async active-high reset
//   enable                 frames start only while high
//   ch_mask [NCH]          channel enables, sampled at frame start
//   ch_valid [NCH]         per-channel new-data flag
//   ch_data [NCH*W]        channel words, ch i at [i*W +: W]
//   ch_ack [NCH]           pulse when channel i is latched for sending
//   tx_busy                spi_master busy (already synchronized)
//   tx_data [W]            word presented to spi_master
//   tx_start               one-cycle start pulse
//   frame_cnt [16]         completed frames, wrapping
//   drop_cnt [16]          stale-data slots, saturating
//   timeout_err            sticky abort flag
//   state_dbg [3]          current FSM state
module spi_link_scheduler
  import spi_link_pkg::*;
#(
  parameter int             NCH       = 4,
  parameter int             W         = SPI_W,
  parameter logic [W-1:0]   SYNC_WORD = SPI_SYNC_WORD,
  parameter int             TMO       = 16
) (
  input  logic             sim_clk,
  input  logic             reset_global,
  input  logic             enable,
  input  logic [NCH-1:0]   ch_mask,
  input  logic [NCH-1:0]   ch_valid,
  input  logic [NCH*W-1:0] ch_data,
  output logic [NCH-1:0]   ch_ack,
  input  logic             tx_busy,
  output logic [W-1:0]     tx_data,
  output logic             tx_start,
  output logic [15:0]      frame_cnt,
  output logic [15:0]      drop_cnt,
  output logic             timeout_err,
  output logic [2:0]       state_dbg
);

  state_e         state_q, state_d;
  logic [NCH-1:0] mask_q;
  logic           slot_sync_q;
  logic [2:0]     slot_idx_q;
  logic [W-1:0]   hold_q [NCH];
  logic [15:0]    tmo_q;

  logic [W-1:0]   cur_word, cur_hold;
  logic           cur_valid;
  logic [2:0]     nxt_idx;
  logic           nxt_found;
  logic           in_wait, tmo_hit;

  prio_next_idx #(.NCH(NCH)) u_prio (
    .mask      (mask_q),
    .from_sync (slot_sync_q),
    .cur_idx   (slot_idx_q),
    .next_idx  (nxt_idx),
    .found     (nxt_found)
  );

  // Current-channel select; ch_ack is only ever driven for the one slot
  // being loaded, which keeps it one-hot by construction.
  always_comb begin
    cur_word  = '0;
    cur_hold  = '0;
    cur_valid = 1'b0;
    ch_ack    = '0;
    for (int i = 0; i < NCH; i++) begin
      if (slot_idx_q == 3'(i)) begin
        cur_word  = ch_data[i*W +: W];
        cur_hold  = hold_q[i];
        cur_valid = ch_valid[i];
        ch_ack[i] = (state_q == ST_LOAD) && !slot_sync_q && ch_valid[i];
      end
    end
  end

  assign in_wait   = (state_q == ST_WAIT_HI) || (state_q == ST_WAIT_LO);
  assign tmo_hit   = (tmo_q == 16'(TMO - 1));
  assign state_dbg = state_q;

  // Next state. Busy edges are tested before the timeout so a busy
  // transition in the expiry cycle wins. START holds off while busy is
  // still high (e.g. a transfer left over from before a reset) so the
  // start strobe never overlaps busy.
  always_comb begin
    state_d  = state_q;
    tx_start = 1'b0;
    case (state_q)
      ST_IDLE:    if (enable) state_d = ST_LOAD;
      ST_LOAD:    state_d = ST_START;
      ST_START: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          state_d  = ST_WAIT_HI;
        end
      end
      ST_WAIT_HI: begin
        if (tx_busy)      state_d = ST_WAIT_LO;
        else if (tmo_hit) state_d = ST_IDLE;
      end
      ST_WAIT_LO: begin
        if (!tx_busy)     state_d = ST_NEXT;
        else if (tmo_hit) state_d = ST_IDLE;
      end
      ST_NEXT:    state_d = nxt_found ? ST_LOAD : ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sim_clk or posedge reset_global) begin
    if (reset_global) begin
      state_q     <= ST_IDLE;
      mask_q      <= '0;
      slot_sync_q <= 1'b1;
      slot_idx_q  <= 3'd0;
      tx_data     <= '0;
      frame_cnt   <= 16'd0;
      drop_cnt    <= 16'd0;
      timeout_err <= 1'b0;
      tmo_q       <= 16'd0;
      for (int i = 0; i < NCH; i++) hold_q[i] <= '0;
    end else begin
      state_q <= state_d;

      // Timeout counter restarts whenever a wait state is entered.
      if (in_wait && (state_d == state_q)) tmo_q <= tmo_q + 16'd1;
      else                                 tmo_q <= 16'd0;

      if (in_wait && (state_d == ST_IDLE)) timeout_err <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (enable) begin
            mask_q      <= ch_mask;
            slot_sync_q <= 1'b1;
            slot_idx_q  <= 3'd0;
          end
        end
        ST_LOAD: begin
          if (slot_sync_q) begin
            tx_data <= SYNC_WORD;
          end else if (cur_valid) begin
            tx_data <= cur_word;
            for (int i = 0; i < NCH; i++)
              if (slot_idx_q == 3'(i)) hold_q[i] <= cur_word;
          end else begin
            tx_data <= cur_hold;
            if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
          end
        end
        ST_NEXT: begin
          if (nxt_found) begin
            slot_sync_q <= 1'b0;
            slot_idx_q  <= nxt_idx;
          end else begin
            frame_cnt <= frame_cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_link_scheduler.sv
// tb_spi_link_scheduler
//   Directed bench for spi_link_scheduler (NCH=4, W=32, TMO=16) with a
//   simple spi_master busy model: busy rises one cycle after tx_start and
//   stays high for four cycles.
module tb_spi_link_scheduler;

  localparam int NCH = 4;
  localparam int W   = 32;
  localparam logic [31:0] SYNC = 32'hA5A5_5A5A;

  logic             sim_clk;
  logic             reset_global;
  logic             enable;
  logic [NCH-1:0]   ch_mask;
  logic [NCH-1:0]   ch_valid;
  logic [NCH*W-1:0] ch_data;
  logic [NCH-1:0]   ch_ack;
  logic             tx_busy;
  logic [W-1:0]     tx_data;
  logic             tx_start;
  logic [15:0]      frame_cnt;
  logic [15:0]      drop_cnt;
  logic             timeout_err;
  logic [2:0]       state_dbg;

  spi_link_scheduler #(.NCH(NCH), .W(W), .SYNC_WORD(SYNC), .TMO(16)) dut (
    .sim_clk      (sim_clk),
    .reset_global (reset_global),
    .enable       (enable),
    .ch_mask      (ch_mask),
    .ch_valid     (ch_valid),
    .ch_data      (ch_data),
    .ch_ack       (ch_ack),
    .tx_busy      (tx_busy),
    .tx_data      (tx_data),
    .tx_start     (tx_start),
    .frame_cnt    (frame_cnt),
    .drop_cnt     (drop_cnt),
    .timeout_err  (timeout_err),
    .state_dbg    (state_dbg)
  );

  int n_cmp = 0;
  int n_bad = 0;

  initial begin
    sim_clk = 1'b0;
    forever #5 sim_clk = ~sim_clk;
  end

  // Busy model
  logic busy_en;
  logic pend;
  int   bcnt;
  initial begin
    tx_busy = 1'b0;
    pend    = 1'b0;
    bcnt    = 0;
  end
  always @(negedge sim_clk) begin
    if (reset_global) begin
      tx_busy = 1'b0;
      pend    = 1'b0;
      bcnt    = 0;
    end else if (bcnt != 0) begin
      bcnt = bcnt - 1;
      if (bcnt == 0) tx_busy = 1'b0;
    end else if (pend) begin
      pend    = 1'b0;
      tx_busy = 1'b1;
      bcnt    = 4;
    end else if (tx_start && busy_en) begin
      pend = 1'b1;
    end
  end

  // Capture of transmitted words and acks
  logic [31:0] words[$];
  logic [31:0] acks[$];
  int          n_start    = 0;
  int          onehot_bad = 0;
  always @(negedge sim_clk) begin
    if (tx_start) begin
      words.push_back(tx_data);
      n_start = n_start + 1;
    end
    if (ch_ack != '0) acks.push_back(32'(ch_ack));
    if ((ch_ack & (ch_ack - 4'd1)) != '0) onehot_bad = onehot_bad + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge sim_clk);
    #1;
  endtask

  task automatic wait_start(input int target, input string tag);
    int i;
    i = 0;
    while (n_start < target && i < 300) begin
      tick();
      i++;
    end
    if (n_start < target) chk(tag, 32'(n_start), 32'(target));
  endtask

  task automatic wait_state(input logic [2:0] st, input string tag);
    int i;
    i = 0;
    while (state_dbg != st && i < 300) begin
      tick();
      i++;
    end
    if (state_dbg != st) chk(tag, 32'(state_dbg), 32'(st));
  endtask

  // Start a frame, drop enable once `drop_after` words have started,
  // then wait for the scheduler to return to IDLE.
  task automatic run_frame(input int drop_after);
    int base;
    base   = n_start;
    enable = 1'b1;
    wait_start(base + drop_after, "frame_start_tmo");
    enable = 1'b0;
    wait_state(3'd0, "frame_idle_tmo");
  endtask

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, "_tx_data"},  tx_data, 32'h0);
    chk({pfx, "_tx_start"}, 32'(tx_start), 32'h0);
    chk({pfx, "_ch_ack"},   32'(ch_ack), 32'h0);
    chk({pfx, "_frame"},    32'(frame_cnt), 32'h0);
    chk({pfx, "_drop"},     32'(drop_cnt), 32'h0);
    chk({pfx, "_tmo_err"},  32'(timeout_err), 32'h0);
    chk({pfx, "_state"},    32'(state_dbg), 32'h0);
  endtask

  function automatic logic [31:0] dval(input int i);
    return 32'h1111_1111 * (i + 1);
  endfunction

  initial begin
    int base, wbase, abase, lat, cnt;
    reset_global = 1'b1;
    enable       = 1'b0;
    busy_en      = 1'b1;
    ch_mask      = '0;
    ch_valid     = '0;
    ch_data      = '0;
    for (int i = 0; i < NCH; i++) ch_data[i*W +: W] = dval(i);
    tick();
    tick();
    check_reset_outputs("rst");
    reset_global = 1'b0;
    tick();

    // 1: mask 0101, all valid
    ch_mask  = 4'b0101;
    ch_valid = 4'b1111;
    wbase = words.size();
    abase = acks.size();
    enable = 1'b1;
    lat = 0;
    while (!tx_start && lat < 20) begin
      tick();
      lat++;
    end
    // enable seen at edge 1 (IDLE), LOAD at edge 2, pulse occupies START cycle
    chk("t1_start_lat", 32'(lat), 32'd2);
    enable = 1'b0;
    tick();
    wait_state(3'd0, "t1_idle_tmo");
    chk("t1_nwords", 32'(words.size() - wbase), 32'd3);
    if (words.size() - wbase == 3) begin
      chk("t1_w0", words[wbase],     SYNC);
      chk("t1_w1", words[wbase + 1], 32'h1111_1111);
      chk("t1_w2", words[wbase + 2], 32'h3333_3333);
    end
    chk("t1_nacks", 32'(acks.size() - abase), 32'd2);
    if (acks.size() - abase == 2) begin
      chk("t1_ack0", acks[abase],     32'h1);
      chk("t1_ack1", acks[abase + 1], 32'h4);
    end
    chk("t1_frame", 32'(frame_cnt), 32'd1);
    chk("t1_drop",  32'(drop_cnt),  32'd0);

    // 2: stale channel resends its held word
    ch_mask = 4'b0010;
    ch_data[1*W +: W] = 32'h3F80_0000;
    run_frame(1);
    ch_valid[1] = 1'b0;
    ch_data[1*W +: W] = 32'hDEAD_BEEF;
    wbase = words.size();
    abase = acks.size();
    run_frame(1);
    chk("t2_nwords", 32'(words.size() - wbase), 32'd2);
    if (words.size() - wbase == 2) begin
      chk("t2_w0", words[wbase],     SYNC);
      chk("t2_w1", words[wbase + 1], 32'h3F80_0000);
    end
    chk("t2_drop",  32'(drop_cnt), 32'd1);
    chk("t2_nacks", 32'(acks.size() - abase), 32'd0);
    chk("t2_frame", 32'(frame_cnt), 32'd3);

    // 3: busy never rises -> timeout after TMO cycles in WAIT_HI
    ch_valid = 4'b1111;
    ch_data[1*W +: W] = dval(1);
    ch_mask = 4'b0001;
    busy_en = 1'b0;
    base = n_start;
    enable = 1'b1;
    wait_start(base + 1, "t3_start_tmo");
    enable = 1'b0;
    cnt = 0;
    while (state_dbg != 3'd0 && cnt < 100) begin
      tick();
      cnt++;
    end
    chk("t3_tmo_cycles", 32'(cnt), 32'd17);
    chk("t3_tmo_err",    32'(timeout_err), 32'd1);
    chk("t3_frame",      32'(frame_cnt), 32'd3);
    busy_en = 1'b1;
    wbase = words.size();
    run_frame(1);
    chk("t3_frame_after", 32'(frame_cnt), 32'd4);
    chk("t3_nwords_after", 32'(words.size() - wbase), 32'd2);
    chk("t3_err_sticky", 32'(timeout_err), 32'd1);

    // 4: reset during WAIT_LO of ch1
    ch_mask = 4'b0010;
    base = n_start;
    enable = 1'b1;
    wait_start(base + 2, "t4_start_tmo");
    wait_state(3'd4, "t4_waitlo_tmo");
    reset_global = 1'b1;
    tick();
    check_reset_outputs("t4");
    tick();
    wbase = words.size();
    base  = n_start;
    reset_global = 1'b0;
    wait_start(base + 1, "t4_restart_tmo");
    enable = 1'b0;
    wait_state(3'd0, "t4_idle_tmo");
    if (words.size() > wbase) chk("t4_first_sync", words[wbase], SYNC);
    chk("t4_frame", 32'(frame_cnt), 32'd1);

    // 5: mask 0 -> SYNC-only frames; frame_cnt wrap
    ch_mask = 4'b0000;
    wbase = words.size();
    run_frame(1);
    run_frame(1);
    chk("t5_nwords", 32'(words.size() - wbase), 32'd2);
    if (words.size() - wbase == 2) chk("t5_w1", words[wbase + 1], SYNC);
    chk("t5_frame", 32'(frame_cnt), 32'd3);
    force dut.frame_cnt = 16'hFFFF;
    tick();
    release dut.frame_cnt;
    tick();
    chk("t5_forced", 32'(frame_cnt), 32'h0000_FFFF);
    run_frame(1);
    chk("t5_wrap", 32'(frame_cnt), 32'd0);

    // 6: enable dropped during ch1 of a full frame
    ch_mask = 4'b1111;
    wbase = words.size();
    abase = acks.size();
    run_frame(3);
    base = n_start;
    for (int i = 0; i < 30; i++) tick();
    chk("t6_no_restart", 32'(n_start), 32'(base));
    chk("t6_state", 32'(state_dbg), 32'd0);
    chk("t6_nwords", 32'(words.size() - wbase), 32'd5);
    if (words.size() - wbase == 5) begin
      chk("t6_w0", words[wbase], SYNC);
      for (int i = 0; i < 4; i++) chk("t6_wch", words[wbase + 1 + i], dval(i));
    end
    chk("t6_nacks", 32'(acks.size() - abase), 32'd4);
    if (acks.size() - abase == 4)
      for (int i = 0; i < 4; i++) chk("t6_ack", acks[abase + i], 32'(1 << i));
    chk("t6_frame", 32'(frame_cnt), 32'd1);
    chk("t6_drop",  32'(drop_cnt), 32'd0);

    chk("ack_onehot", 32'(onehot_bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
